// File: rtl/mp_reg_file_sb_if.sv
// Bus interface for mp_reg_file_sb: read ports, write-back ports, issue port
// and the scoreboard vector. The master drives requests; the slave is the
// register file.
interface mp_reg_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                       enable;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic [NUM_REGS-1:0]        busy_vec;

  modport master (
    output enable, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  enable, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/mp_reg_file_sb.sv
// Multi-port register file with per-register pending-write scoreboard for the
// pipelined MIPS core. NUM_RD combinational read ports, NUM_WR write-back
// ports, register 0 hardwired to zero. Busy bits feed decode hazard checks.
// Optional feature macro: REG_BYPASS_EN -- forwards same-cycle write-back data
// (and the resulting busy state) onto the read ports.
module mp_reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic            clk,
  input  logic            reset,
  mp_reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  logic [ADDR_W-1:0]   ra [NUM_RD];
  logic [ADDR_W-1:0]   wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_live;
  logic                iss_live;

  // Unpack the flat port buses; a request is live only when enabled and not
  // aimed at the hardwired zero register.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
    assign ra[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
  end

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wa[k]      = bus.wr_addr[k*ADDR_W +: ADDR_W];
    assign wd[k]      = bus.wr_data[k*DATA_W +: DATA_W];
    assign wr_live[k] = bus.enable && bus.wr_en[k] && (wa[k] != '0);
  end

  assign iss_live = bus.enable && bus.iss_en && (bus.iss_addr != '0);

  // Read value for one port: stored contents, optionally overridden by the
  // highest-indexed live write to the same address.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
`ifdef REG_BYPASS_EN
    if (!reset) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_live[k] && (wa[k] == a)) v = wd[k];
      end
    end
`endif
    if (a == '0) v = '0;
    return v;
  endfunction

  // Busy bit for one port: a forwarded write means the value is ready,
  // unless a new producer is being issued to the same register this cycle.
  function automatic logic read_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy[a];
`ifdef REG_BYPASS_EN
    begin
      logic hit;
      hit = 1'b0;
      if (!reset) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_live[k] && (wa[k] == a)) hit = 1'b1;
        end
      end
      if (hit) b = iss_live && (bus.iss_addr == a);
    end
`endif
    if (a == '0) b = 1'b0;
    return b;
  endfunction

  // Next state: write-backs in ascending port order so the highest port wins,
  // then issue, so a same-cycle issue leaves the register busy.
  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_live[k]) begin
        regs_nxt[wa[k]] = wd[k];
        busy_nxt[wa[k]] = 1'b0;
      end
    end
    if (iss_live) busy_nxt[bus.iss_addr] = 1'b1;
  end

  // State registers; reset clears contents and scoreboard immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
      busy <= busy_nxt;
    end
  end

  // Zero-latency read ports.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = read_word(ra[p]);
      bus.rd_busy[p]                  = read_busy(ra[p]);
    end
  end

  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_mp_reg_file_sb.sv
// Scoreboard bench for mp_reg_file_sb: the driver pushes the expected read
// view (from an array model of the register file) for each applied cycle; a
// monitor pops and compares once inputs have settled mid-cycle.
module tb_mp_reg_file_sb;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mp_reg_file_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  mp_reg_file_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Stimulus for the next cycle
  logic              d_reset;
  logic              d_enable;
  logic [ADDR_W-1:0] d_rd_addr [NUM_RD];
  logic [NUM_WR-1:0] d_wr_en;
  logic [ADDR_W-1:0] d_wr_addr [NUM_WR];
  logic [DATA_W-1:0] d_wr_data [NUM_WR];
  logic              d_iss_en;
  logic [ADDR_W-1:0] d_iss_addr;

  // Reference model: plain register array and busy set
  logic [DATA_W-1:0]   m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_busy;

  typedef struct packed {
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_REGS-1:0]      busy_vec;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic void model_clear();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endfunction

  // Architectural effect of one clock edge: write-backs in port order (later
  // port overrides), each clears its pending flag; then the issue marks
  // its destination pending.
  function automatic void model_edge();
    if (d_reset || !d_enable) return;
    for (int k = 0; k < NUM_WR; k++) begin
      if (d_wr_en[k] && d_wr_addr[k] != 0) begin
        m_regs[d_wr_addr[k]] = d_wr_data[k];
        m_busy[d_wr_addr[k]] = 1'b0;
      end
    end
    if (d_iss_en && d_iss_addr != 0) m_busy[d_iss_addr] = 1'b1;
  endfunction

  function automatic void push_expect(input string nm);
    exp_t e;
    e.rd_data  = '0;
    e.rd_busy  = '0;
    e.busy_vec = m_busy;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      logic              b;
      logic              hit;
      a   = d_rd_addr[p];
      v   = m_regs[a];
      b   = m_busy[a];
      hit = 1'b0;
`ifdef REG_BYPASS_EN
      if (!d_reset && d_enable) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (d_wr_en[k] && d_wr_addr[k] == a && a != 0) begin
            hit = 1'b1;
            v   = d_wr_data[k];
          end
        end
        if (hit) b = d_iss_en && (d_iss_addr == a);
      end
`endif
      if (a == 0) begin
        v = '0;
        b = 1'b0;
      end
      e.rd_data[p*DATA_W +: DATA_W] = v;
      e.rd_busy[p] = b;
    end
    sb_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  function automatic void apply();
    reset        = d_reset;
    bus.enable   = d_enable;
    bus.wr_en    = d_wr_en;
    bus.iss_en   = d_iss_en;
    bus.iss_addr = d_iss_addr;
    for (int p = 0; p < NUM_RD; p++) bus.rd_addr[p*ADDR_W +: ADDR_W] = d_rd_addr[p];
    for (int k = 0; k < NUM_WR; k++) begin
      bus.wr_addr[k*ADDR_W +: ADDR_W] = d_wr_addr[k];
      bus.wr_data[k*DATA_W +: DATA_W] = d_wr_data[k];
    end
  endfunction

  function automatic void idle();
    d_reset  = 1'b0;
    d_enable = 1'b1;
    d_wr_en  = '0;
    d_iss_en = 1'b0;
    d_iss_addr = '0;
    for (int p = 0; p < NUM_RD; p++) d_rd_addr[p] = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      d_wr_addr[k] = '0;
      d_wr_data[k] = '0;
    end
  endfunction

  // Apply stimulus just after the falling edge, record the expected view,
  // then advance the model across the rising edge.
  task automatic cycle(input string nm);
    @(negedge clk);
    #1;
    apply();
    if (d_reset) model_clear();
    push_expect(nm);
    @(posedge clk);
    model_edge();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, NUM_REGS-1));
    return ADDR_W'($urandom_range(0, 7));
  endfunction

  // Monitor: compares every pending expectation once the inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        exp_t  e;
        string nm;
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if (bus.rd_data !== e.rd_data) begin
          n_fail++;
          $display("FAIL %s rd_data got %h expected %h", nm, bus.rd_data, e.rd_data);
        end
        n_tests++;
        if (bus.rd_busy !== e.rd_busy) begin
          n_fail++;
          $display("FAIL %s rd_busy got %b expected %b", nm, bus.rd_busy, e.rd_busy);
        end
        n_tests++;
        if (bus.busy_vec !== e.busy_vec) begin
          n_fail++;
          $display("FAIL %s busy_vec got %h expected %h", nm, bus.busy_vec, e.busy_vec);
        end
      end
    end
  end

  initial begin
    model_clear();
    idle();
    d_reset = 1'b1;
    apply();
    cycle("reset_hold0");
    cycle("reset_hold1");

    // Fill every register and mark a few pending, then reset mid-operation.
    idle();
    for (int i = 1; i < NUM_REGS; i += 2) begin
      d_wr_en = 2'b11;
      d_wr_addr[0] = ADDR_W'(i);
      d_wr_addr[1] = ADDR_W'((i + 1) % NUM_REGS);
      d_wr_data[0] = $urandom;
      d_wr_data[1] = $urandom;
      d_rd_addr[0] = ADDR_W'(i);
      d_rd_addr[1] = ADDR_W'(i - 1);
      d_iss_en   = 1'b1;
      d_iss_addr = ADDR_W'((i + 5) % NUM_REGS);
      cycle("fill");
    end
    idle();
    d_rd_addr[0] = 5;
    d_rd_addr[1] = 9;
    cycle("fill_readback");
    d_reset = 1'b1;
    d_wr_en = 2'b11;
    d_wr_addr[0] = 5;
    d_wr_addr[1] = 9;
    d_wr_data[0] = 32'h1111_1111;
    d_wr_data[1] = 32'h2222_2222;
    d_iss_en = 1'b1;
    d_iss_addr = 12;
    cycle("reset_async");
    cycle("reset_held");
    idle();
    d_rd_addr[0] = 5;
    d_rd_addr[1] = 9;
    cycle("reset_released");

    // Two ports writing the same register: port 1 wins.
    idle();
    d_wr_en = 2'b11;
    d_wr_addr[0] = 5;
    d_wr_addr[1] = 5;
    d_wr_data[0] = 32'hAAAA_0000;
    d_wr_data[1] = 32'h5555_FFFF;
    d_rd_addr[0] = 5;
    cycle("conflict_write");
    idle();
    d_rd_addr[0] = 5;
    cycle("conflict_read");

    // Writes and issues to register 0 are ignored.
    idle();
    d_wr_en = 2'b01;
    d_wr_addr[0] = 0;
    d_wr_data[0] = 32'hDEAD_BEEF;
    d_iss_en = 1'b1;
    d_iss_addr = 0;
    cycle("zero_write");
    idle();
    cycle("zero_read");

    // Scoreboard: issue, issue+write same cycle, write alone.
    idle();
    d_rd_addr[1] = 7;
    d_iss_en = 1'b1;
    d_iss_addr = 7;
    cycle("iss7");
    d_wr_en = 2'b10;
    d_wr_addr[1] = 7;
    d_wr_data[1] = 32'h0000_0777;
    cycle("iss7_wr7");
    idle();
    d_rd_addr[1] = 7;
    cycle("iss7_wr7_after");
    d_wr_en = 2'b01;
    d_wr_addr[0] = 7;
    d_wr_data[0] = 32'h0000_7070;
    cycle("wr7");
    idle();
    d_rd_addr[1] = 7;
    cycle("wr7_after");

    // Write-to-read latency (forwarded when bypass is built in).
    idle();
    d_rd_addr[0] = 3;
    d_wr_en = 2'b01;
    d_wr_addr[0] = 3;
    d_wr_data[0] = 32'h1234_5678;
    cycle("wr3_same_cycle");
    idle();
    d_rd_addr[0] = 3;
    cycle("wr3_next_cycle");

    // Disabled: requests ignored, reads live.
    d_enable = 1'b0;
    d_wr_en = 2'b11;
    d_wr_addr[0] = 3;
    d_wr_addr[1] = 7;
    d_wr_data[0] = 32'hFFFF_0000;
    d_wr_data[1] = 32'h0000_FFFF;
    d_iss_en = 1'b1;
    d_iss_addr = 3;
    d_rd_addr[0] = 3;
    d_rd_addr[1] = 7;
    cycle("disabled");
    idle();
    d_rd_addr[0] = 3;
    d_rd_addr[1] = 7;
    cycle("disabled_after");

    // Randomised traffic with occasional mid-burst reset.
    for (int n = 0; n < 400; n++) begin
      d_reset  = ($urandom_range(0, 49) == 0);
      d_enable = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NUM_WR; k++) begin
        d_wr_en[k]   = 1'($urandom_range(0, 1));
        d_wr_addr[k] = rand_addr();
        d_wr_data[k] = $urandom;
      end
      d_iss_en   = 1'($urandom_range(0, 1));
      d_iss_addr = $urandom_range(0, 1) ? d_wr_addr[$urandom_range(0, NUM_WR-1)] : rand_addr();
      for (int p = 0; p < NUM_RD; p++)
        d_rd_addr[p] = $urandom_range(0, 1) ? d_wr_addr[$urandom_range(0, NUM_WR-1)] : rand_addr();
      cycle("random");
    end

    idle();
    cycle("final");
    @(negedge clk);
    #3;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending %0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
